alu_op_sequencer: RTL and testbench

- Issue/capture stage directly upstream of the 9-op ArithmeticLogicUnit.
- Accepts one operation request (op, X, Y) over a valid/ready handshake.
- Drives the ALU with stable operands for a fixed per-class latency, then captures result/remainder into an output register held under valid/ready backpressure.
- Keeps the ALU at op 0 (idle, all unit-active lines low) between operations so the multiplier and divider restart cleanly on every issue.

---
 rtl/alu_op_sequencer_if.sv | 24 ++
 rtl/alu_op_sequencer.sv | 175 +++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_if.sv
// Request/response bus of the ALU operation sequencer.
// The master drives requests and consumes results; the slave is the sequencer.
interface alu_op_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_op;
    logic [31:0] in_x;
    logic [31:0] in_y;
    logic        out_valid;
    logic        out_ready;
    logic [66:0] out_result;
    logic [32:0] out_remainder;
    logic        out_err;

    modport master (
        output in_valid, in_op, in_x, in_y, out_ready,
        input  in_ready, out_valid, out_result, out_remainder, out_err
    );

    modport slave (
        input  in_valid, in_op, in_x, in_y, out_ready,
        output in_ready, out_valid, out_result, out_remainder, out_err
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// ALU operation sequencer: accepts one (op, X, Y) request and drives the ALU
// with stable operands for a per-class latency. It then captures the
// result/remainder into an output register that is held under backpressure.
// The ALU is parked at op 0 between operations so the multi-cycle units
// restart cleanly on every issue.
// Optional feature macro: DIV0_CHECK_EN rejects divide-by-zero at issue.
module alu_op_sequencer #(
    parameter int unsigned ADD_LAT   = 1,
    parameter int unsigned MUL_LAT   = 34,
    parameter int unsigned DIV_LAT   = 34,
    parameter int unsigned LOGIC_LAT = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    alu_op_sequencer_if.slave         bus,
    output logic [4:0]                alu_op,
    output logic [31:0]               alu_x,
    output logic [31:0]               alu_y,
    input  logic [66:0]               alu_result,
    input  logic [32:0]               alu_remainder,
    output logic                      busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Hold time on the ALU for each opcode class.
    function automatic logic [5:0] lat_of(input logic [4:0] op);
        logic [5:0] lat;
        case (op)
            5'd1, 5'd2: lat = 6'(ADD_LAT);
            5'd3:       lat = 6'(MUL_LAT);
            5'd4:       lat = 6'(DIV_LAT);
            5'd5, 5'd6, 5'd7, 5'd8, 5'd9: lat = 6'(LOGIC_LAT);
            default:    lat = 6'd1;
        endcase
        return lat;
    endfunction

    function automatic logic is_legal(input logic [4:0] op);
        return (op >= 5'd1) && (op <= 5'd9);
    endfunction

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [4:0]  alu_op_q, alu_op_d;
    logic [31:0] alu_x_q, alu_x_d;
    logic [31:0] alu_y_q, alu_y_d;
    logic        out_valid_q, out_valid_d;
    logic [66:0] out_result_q, out_result_d;
    logic [32:0] out_remainder_q, out_remainder_d;
    logic        out_err_q, out_err_d;
    logic        busy_q, busy_d;

    logic        div0_s;
    logic        reject_s;
    logic [32:0] reject_rem_s;

`ifdef DIV0_CHECK_EN
    assign div0_s = (bus.in_op == 5'd4) && (bus.in_y == 32'd0);
`else
    assign div0_s = 1'b0;
`endif

    // A rejected divide-by-zero reports X in the remainder; other rejects report 0.
    assign reject_s     = !is_legal(bus.in_op) || div0_s;
    assign reject_rem_s = div0_s ? {1'b0, bus.in_x} : 33'd0;

    // Next-state, counter and output-register computation.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        alu_op_d        = alu_op_q;
        alu_x_d         = alu_x_q;
        alu_y_d         = alu_y_q;
        out_valid_d     = out_valid_q;
        out_result_d    = out_result_q;
        out_remainder_d = out_remainder_q;
        out_err_d       = out_err_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    if (reject_s) begin
                        out_result_d    = 67'd0;
                        out_remainder_d = reject_rem_s;
                        out_err_d       = 1'b1;
                        out_valid_d     = 1'b1;
                        state_d         = ST_DONE;
                    end else begin
                        alu_op_d = bus.in_op;
                        alu_x_d  = bus.in_x;
                        alu_y_d  = bus.in_y;
                        cnt_d    = lat_of(bus.in_op);
                        state_d  = ST_RUN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_q == 6'd1) begin
                    out_result_d    = alu_result;
                    out_remainder_d = (alu_op_q == 5'd4) ? alu_remainder : 33'd0;
                    out_err_d       = 1'b0;
                    out_valid_d     = 1'b1;
                    alu_op_d        = 5'd0;
                    alu_x_d         = 32'd0;
                    alu_y_d         = 32'd0;
                    cnt_d           = 6'd0;
                    state_d         = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                cnt_d       = 6'd0;
                alu_op_d    = 5'd0;
                alu_x_d     = 32'd0;
                alu_y_d     = 32'd0;
                out_valid_d = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset abandons any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            cnt_q           <= 6'd0;
            alu_op_q        <= 5'd0;
            alu_x_q         <= 32'd0;
            alu_y_q         <= 32'd0;
            out_valid_q     <= 1'b0;
            out_result_q    <= 67'd0;
            out_remainder_q <= 33'd0;
            out_err_q       <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            alu_op_q        <= alu_op_d;
            alu_x_q         <= alu_x_d;
            alu_y_q         <= alu_y_d;
            out_valid_q     <= out_valid_d;
            out_result_q    <= out_result_d;
            out_remainder_q <= out_remainder_d;
            out_err_q       <= out_err_d;
            busy_q          <= busy_d;
        end
    end

    assign bus.in_ready      = !rst && (state_q == ST_IDLE);
    assign bus.out_valid     = out_valid_q;
    assign bus.out_result    = out_result_q;
    assign bus.out_remainder = out_remainder_q;
    assign bus.out_err       = out_err_q;
    assign alu_op            = alu_op_q;
    assign alu_x             = alu_x_q;
    assign alu_y             = alu_y_q;
    assign busy              = busy_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer with a behavioural ALU model.
module tb_alu_op_sequencer;

    logic        clk;
    logic        rst;
    logic [4:0]  alu_op;
    logic [31:0] alu_x;
    logic [31:0] alu_y;
    logic [66:0] alu_result;
    logic [32:0] alu_remainder;
    logic        busy;

    alu_op_sequencer_if bus ();

    alu_op_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .alu_op        (alu_op),
        .alu_x         (alu_x),
        .alu_y         (alu_y),
        .alu_result    (alu_result),
        .alu_remainder (alu_remainder),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU model; idle op and non-divide remainders are deliberately nonzero.
    logic [63:0] prod_s;
    always_comb begin
        prod_s        = 64'(alu_x) * 64'(alu_y);
        alu_result    = 67'h1_2345;
        alu_remainder = {1'b1, alu_x ^ alu_y};
        case (alu_op)
            5'd1: alu_result = {35'd0, alu_x} + {35'd0, alu_y};
            5'd2: alu_result = {35'd0, alu_x} - {35'd0, alu_y};
            5'd3: alu_result = {3'd0, prod_s};
            5'd4: begin
                if (alu_y != 32'd0) begin
                    alu_result    = {35'd0, alu_x / alu_y};
                    alu_remainder = {1'b0, alu_x % alu_y};
                end else begin
                    alu_result    = 67'd0;
                    alu_remainder = {1'b0, alu_x};
                end
            end
            5'd5: alu_result = {35'd0, alu_x << alu_y[4:0]};
            5'd6: alu_result = {35'd0, alu_x >> alu_y[4:0]};
            5'd7: alu_result = {35'd0, alu_x & alu_y};
            5'd8: alu_result = {35'd0, alu_x | alu_y};
            5'd9: alu_result = {35'd0, alu_x ^ alu_y};
            default: alu_result = 67'h1_2345;
        endcase
    end

    typedef struct {
        logic [4:0]  op;
        logic [31:0] x;
        logic [31:0] y;
        logic [66:0] res;
        logic [32:0] rem;
        logic        err;
        int          lat;
        int          bp;
    } vec_t;

    typedef struct {
        logic [66:0] res;
        logic [32:0] rem;
        logic        err;
    } exp_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];
    exp_t sb [$];
    int   pass_cnt = 0;
    int   tot_cnt  = 0;

    task automatic chk(input string name, input logic [66:0] act, input logic [66:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic wait_ready();
        int w;
        w = 0;
        while (bus.in_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("in_ready_before_issue", 67'(bus.in_ready), 67'd1);
    endtask

    task automatic run_vec(input vec_t v);
        int   n;
        int   alu_cyc;
        bit   held_ok;
        bit   stable_ok;
        bit   got;
        exp_t e;
        wait_ready();
        bus.out_ready = (v.bp == 0);
        bus.in_valid  = 1'b1;
        bus.in_op     = v.op;
        bus.in_x      = v.x;
        bus.in_y      = v.y;
        sb.push_back('{v.res, v.rem, v.err});
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_x     = ~v.x;
        bus.in_y     = ~v.y;
        bus.in_op    = 5'd7;
        n = 0; alu_cyc = 0; held_ok = 1'b1; got = 1'b0;
        while (!got && n < 100) begin
            @(negedge clk);
            n++;
            if (bus.out_valid === 1'b1) begin
                got = 1'b1;
            end else begin
                if (alu_op !== 5'd0) begin
                    alu_cyc++;
                    if (alu_op !== v.op || alu_x !== v.x || alu_y !== v.y) held_ok = 1'b0;
                end
                if (busy !== 1'b1 || bus.in_ready !== 1'b0) held_ok = 1'b0;
            end
        end
        chk("out_valid_latency", 67'(n), 67'(v.lat));
        chk("alu_drive_cycles", 67'(alu_cyc), 67'(v.lat - 1));
        chk("alu_operands_held", 67'(held_ok), 67'd1);
        chk("no_accept_in_done", 67'(bus.in_ready), 67'd0);
        chk("alu_idle_in_done", 67'(alu_op), 67'd0);
        if (sb.size() == 0) begin
            chk("scoreboard_nonempty", 67'd0, 67'd1);
        end else begin
            e = sb.pop_front();
            chk("out_result", bus.out_result, e.res);
            chk("out_remainder", 67'(bus.out_remainder), 67'(e.rem));
            chk("out_err", 67'(bus.out_err), 67'(e.err));
        end
        if (v.bp > 0) begin
            stable_ok = 1'b1;
            repeat (v.bp) begin
                @(negedge clk);
                if (bus.out_valid !== 1'b1 || bus.out_result !== v.res ||
                    bus.out_err !== v.err || bus.in_ready !== 1'b0 || alu_op !== 5'd0)
                    stable_ok = 1'b0;
            end
            chk("backpressure_hold", 67'(stable_ok), 67'd1);
            bus.out_ready = 1'b1;
        end
        @(negedge clk);
        chk("out_valid_cleared", 67'(bus.out_valid), 67'd0);
        chk("in_ready_after_done", 67'(bus.in_ready), 67'd1);
        chk("out_result_retained", bus.out_result, v.res);
    endtask

    initial begin
        vecs[0]  = '{5'd1, 32'd5, 32'd7, 67'd12, 33'd0, 1'b0, 2, 0};
        vecs[1]  = '{5'd3, 32'd3, 32'd4, 67'd12, 33'd0, 1'b0, 35, 0};
        vecs[2]  = '{5'd4, 32'd100, 32'd7, 67'd14, 33'd2, 1'b0, 35, 0};
        vecs[3]  = '{5'd7, 32'h0000_F0F0, 32'h0000_FF00, 67'h0000_F000, 33'd0, 1'b0, 2, 0};
        vecs[4]  = '{5'd0, 32'd11, 32'd22, 67'd0, 33'd0, 1'b1, 1, 5};
        vecs[5]  = '{5'd12, 32'd33, 32'd44, 67'd0, 33'd0, 1'b1, 1, 5};
        vecs[6]  = '{5'd2, 32'd9, 32'd4, 67'd5, 33'd0, 1'b0, 2, 0};
        vecs[7]  = '{5'd5, 32'd1, 32'd4, 67'd16, 33'd0, 1'b0, 2, 0};
        vecs[8]  = '{5'd9, 32'h0000_00FF, 32'h0000_000F, 67'h0000_00F0, 33'd0, 1'b0, 2, 2};
        vecs[9]  = '{5'd8, 32'h0000_00A0, 32'h0000_0005, 67'h0000_00A5, 33'd0, 1'b0, 2, 0};
        vecs[10] = '{5'd31, 32'd1, 32'd1, 67'd0, 33'd0, 1'b1, 1, 0};
        vecs[11] = '{5'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 67'h0_FFFF_FFFE_0000_0001, 33'd0, 1'b0, 35, 0};
`ifdef DIV0_CHECK_EN
        vecs[12] = '{5'd4, 32'd50, 32'd0, 67'd0, 33'd50, 1'b1, 1, 0};
`else
        vecs[12] = '{5'd4, 32'd50, 32'd0, 67'd0, 33'd50, 1'b0, 35, 0};
`endif
        vecs[13] = '{5'd6, 32'h0000_0080, 32'd3, 67'h10, 33'd0, 1'b0, 2, 0};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_op     = 5'd0;
        bus.in_x      = 32'd0;
        bus.in_y      = 32'd0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", 67'(bus.in_ready), 67'd0);
        chk("reset_busy", 67'(busy), 67'd0);
        chk("reset_out_valid", 67'(bus.out_valid), 67'd0);
        chk("reset_alu_op", 67'(alu_op), 67'd0);
        chk("reset_out_result", bus.out_result, 67'd0);
        chk("reset_out_err", 67'(bus.out_err), 67'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NVEC; i++) run_vec(vecs[i]);

        // Reset ten cycles into a multiply abandons it immediately.
        wait_ready();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_op     = 5'd3;
        bus.in_x      = 32'd6;
        bus.in_y      = 32'd7;
        sb.push_back('{67'd42, 33'd0, 1'b0});
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid_mul_alu_op", 67'(alu_op), 67'd3);
        rst = 1'b1;
        #1;
        chk("mid_reset_alu_op", 67'(alu_op), 67'd0);
        chk("mid_reset_out_valid", 67'(bus.out_valid), 67'd0);
        chk("mid_reset_busy", 67'(busy), 67'd0);
        chk("mid_reset_in_ready", 67'(bus.in_ready), 67'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_vec('{5'd2, 32'd9, 32'd4, 67'd5, 33'd0, 1'b0, 2, 0});
        chk("scoreboard_drained", 67'(sb.size()), 67'd0);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
